bitblade_mac_ctrl: RTL and testbench

CFU-side sequencer for the Bitblade configurable MAC. It accepts 32-bit two-operand CFU commands and assembles 8-bit (one beat) or 4-bit (two beats, 64+64 bits) operand sets. It drives the Bitblade mode and operand inputs through a registered pipeline and accumulates the 18-bit Bitblade result into a saturating accumulator. It sits between the CPU CFU port and one Bitblade instance; the Bitblade is connected externally through the bb_* ports.

---
 rtl/bitblade_mac_ctrl.sv | 154 +++++++++++++++
 tb/tb_bitblade_mac_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitblade_mac_ctrl.sv
// CFU-side sequencer for one Bitblade MAC: assembles 8-bit or split 4-bit operand
// sets, drives registered bb_* operands and saturating-accumulates the result.
module bitblade_mac_ctrl #(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload,
  output logic        bb_mode,
  output logic [63:0] bb_in_a,
  output logic [63:0] bb_in_b,
  input  logic [17:0] bb_out_c
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both
  // high; the sender holds valid and its data stable until that edge.

  localparam logic [2:0] OP_CLEAR   = 3'd0;
  localparam logic [2:0] OP_MAC8    = 3'd1;
  localparam logic [2:0] OP_MAC4_LO = 3'd2;
  localparam logic [2:0] OP_MAC4_HI = 3'd3;
  localparam logic [2:0] OP_READ    = 3'd4;
  localparam logic [2:0] OP_STATUS  = 3'd5;
  localparam logic [2:0] OP_CLR_ST  = 3'd6;
  localparam logic [2:0] OP_LOAD    = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_HI, S_EXEC, S_ACC, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic             err, ovf, lo_pend;
  logic [31:0]      lo_a, lo_b;
  logic [17:0]      prod_q;
  logic             accept, in_wait_hi, is_mac;
  logic [31:0]      acc_ext, load_ext;
  logic [ACC_W:0]   prod_ext, sum;
  logic [ACC_W-1:0] sat_acc;

  assign cmd_ready  = (state == S_IDLE) || (state == S_WAIT_HI);
  assign accept     = cmd_valid && cmd_ready;
  assign in_wait_hi = (state == S_WAIT_HI);
  assign is_mac     = (cmd_op == OP_MAC8) || (cmd_op == OP_MAC4_HI);

  always_comb begin
    acc_ext                = '0;
    acc_ext[ACC_W-1:0]     = acc;
    load_ext               = '0;
    load_ext[ACC_W-1:0]    = cmd_rs1[ACC_W-1:0];
    prod_ext               = '0;
    prod_ext[17:0]         = prod_q;
    sum                    = {1'b0, acc} + prod_ext;
    sat_acc                = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_WAIT_HI: if (accept) state_nxt = is_mac ? S_EXEC : S_RESP;
      S_EXEC:            state_nxt = S_ACC;
      S_ACC:             state_nxt = S_RESP;
      S_RESP:            if (rsp_ready) state_nxt = lo_pend ? S_WAIT_HI : S_IDLE;
      default:           state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      err         <= 1'b0;
      ovf         <= 1'b0;
      lo_pend     <= 1'b0;
      lo_a        <= '0;
      lo_b        <= '0;
      prod_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_payload <= '0;
      bb_mode     <= 1'b0;
      bb_in_a     <= '0;
      bb_in_b     <= '0;
    end else begin
      case (state)
        S_IDLE, S_WAIT_HI: begin
          if (accept) begin
            // Any opcode other than a 4-bit half breaks a pending pair.
            if (in_wait_hi && cmd_op != OP_MAC4_HI && cmd_op != OP_MAC4_LO) begin
              err     <= 1'b1;
              lo_pend <= 1'b0;
            end
            if (!is_mac) rsp_valid <= 1'b1;
            case (cmd_op)
              OP_CLEAR: begin
                acc         <= '0;
                rsp_payload <= '0;
              end
              OP_MAC8: begin
                bb_mode <= 1'b0;
                bb_in_a <= {32'b0, cmd_rs1};
                bb_in_b <= {32'b0, cmd_rs2};
              end
              OP_MAC4_LO: begin
                if (in_wait_hi) err <= 1'b1;
                lo_a        <= cmd_rs1;
                lo_b        <= cmd_rs2;
                lo_pend     <= 1'b1;
                rsp_payload <= acc_ext;
              end
              OP_MAC4_HI: begin
                if (!in_wait_hi) err <= 1'b1;
                bb_mode <= 1'b1;
                bb_in_a <= {cmd_rs1, in_wait_hi ? lo_a : 32'b0};
                bb_in_b <= {cmd_rs2, in_wait_hi ? lo_b : 32'b0};
                lo_pend <= 1'b0;
              end
              OP_READ:   rsp_payload <= acc_ext;
              OP_STATUS: rsp_payload <= {30'b0, ovf, err | in_wait_hi};
              OP_CLR_ST: begin
                err         <= 1'b0;
                ovf         <= 1'b0;
                rsp_payload <= '0;
              end
              default: begin
                acc         <= cmd_rs1[ACC_W-1:0];
                rsp_payload <= load_ext;
              end
            endcase
          end
        end
        S_EXEC: prod_q <= bb_out_c;
        S_ACC: begin
          acc                       <= sat_acc;
          rsp_payload               <= '0;
          rsp_payload[ACC_W-1:0]    <= sat_acc;
          rsp_valid                 <= 1'b1;
          if (sum[ACC_W]) ovf       <= 1'b1;
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitblade_mac_ctrl.sv
// Directed bench for bitblade_mac_ctrl with a behavioural Bitblade dot-product model
// and a queue-based response scoreboard.
module tb_bitblade_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_rs1 = '0;
  logic [31:0] cmd_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_payload;
  logic        bb_mode;
  logic [63:0] bb_in_a, bb_in_b;
  logic [17:0] bb_out_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_cyc_q[$];
  logic        seen = 1'b0;

  bitblade_mac_ctrl #(.ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload(rsp_payload),
    .bb_mode(bb_mode), .bb_in_a(bb_in_a), .bb_in_b(bb_in_b), .bb_out_c(bb_out_c)
  );

  // Bitblade stand-in: unsigned dot product over byte lanes or nibble lanes.
  function automatic logic [17:0] bb_model(logic mode, logic [63:0] a, logic [63:0] b);
    int s;
    s = 0;
    if (mode) for (int i = 0; i < 16; i++) s += int'(a[i*4 +: 4]) * int'(b[i*4 +: 4]);
    else      for (int i = 0; i < 4; i++)  s += int'(a[i*8 +: 8]) * int'(b[i*8 +: 8]);
    return 18'(s);
  endfunction

  assign bb_out_c = bb_model(bb_mode, bb_in_a, bb_in_b);

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_rs1 = a; cmd_rs2 = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout op%0d: got cmd_ready=0 expected 1", op);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    acc_cyc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_cyc_q.delete();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (lat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
        end else begin
          int l, c;
          l = lat_q.pop_front();
          c = acc_cyc_q.pop_front();
          checks++;
          if (cyc - c + 1 != l) begin
            errors++;
            $display("FAIL rsp_latency: got %0d expected %0d", cyc - c + 1, l);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checks++;
          if (rsp_payload !== e) begin
            errors++;
            $display("FAIL rsp_payload: got 0x%0h expected 0x%0h", rsp_payload, e);
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_payload", 64'(rsp_payload), 64'd0);
    chk("rst_bb_mode", 64'(bb_mode), 64'd0);
    chk("rst_bb_in_a", bb_in_a, 64'd0);
    chk("rst_bb_in_b", bb_in_b, 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;

    // 8-bit MAC: 1*4? no -- lanes 4*1+3*1+2*1+1*1 = 10
    issue(3'd0, 32'h0, 32'h0, 32'd0, 1);
    issue(3'd1, 32'h01020304, 32'h01010101, 32'd10, 3);
    issue(3'd4, 32'h0, 32'h0, 32'd10, 1);
    drain();

    // 4-bit pair: 16 lanes of 1*2 = 32
    issue(3'd0, 32'h0, 32'h0, 32'd0, 1);
    issue(3'd2, 32'h11111111, 32'h22222222, 32'd0, 1);
    issue(3'd3, 32'h11111111, 32'h22222222, 32'd32, 3);
    drain();
    chk("mac4_bb_mode", 64'(bb_mode), 64'd1);
    chk("mac4_bb_in_a", bb_in_a, 64'h1111111111111111);
    chk("mac4_bb_in_b", bb_in_b, 64'h2222222222222222);

    // saturation: 0xFFFFFFF0 + 65025 overflows
    issue(3'd7, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 1);
    issue(3'd1, 32'h000000FF, 32'h000000FF, 32'hFFFFFFFF, 3);
    issue(3'd5, 32'h0, 32'h0, 32'h2, 1);
    issue(3'd6, 32'h0, 32'h0, 32'h0, 1);
    issue(3'd5, 32'h0, 32'h0, 32'h0, 1);
    drain();
    chk("mac8_bb_mode", 64'(bb_mode), 64'd0);
    chk("mac8_bb_in_a", bb_in_a, 64'h00000000000000FF);

    // broken pair, then orphan HI with zero low halves: 8 lanes of 1*2 = 16
    issue(3'd0, 32'h0, 32'h0, 32'd0, 1);
    issue(3'd2, 32'h11111111, 32'h22222222, 32'd0, 1);
    issue(3'd4, 32'h0, 32'h0, 32'd0, 1);
    issue(3'd5, 32'h0, 32'h0, 32'h1, 1);
    issue(3'd3, 32'h11111111, 32'h22222222, 32'd16, 3);
    issue(3'd5, 32'h0, 32'h0, 32'h1, 1);
    drain();
    chk("orphan_bb_in_a", bb_in_a, 64'h1111111100000000);
    chk("orphan_bb_in_b", bb_in_b, 64'h2222222200000000);

    // LO while pending overwrites halves: 8 lanes of 3*1 = 24, acc 16 -> 40
    issue(3'd6, 32'h0, 32'h0, 32'h0, 1);
    issue(3'd2, 32'h11111111, 32'h22222222, 32'd16, 1);
    issue(3'd2, 32'h33333333, 32'h11111111, 32'd16, 1);
    issue(3'd3, 32'h0, 32'h0, 32'd40, 3);
    issue(3'd5, 32'h0, 32'h0, 32'h1, 1);
    drain();
    chk("relo_bb_in_a", bb_in_a, 64'h0000000033333333);

    // backpressure: 2*3 = 6, acc 40 -> 46
    rsp_ready = 1'b0;
    issue(3'd1, 32'h2, 32'h3, 32'd46, 3);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_payload", 64'(rsp_payload), 64'd46);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      cmd_op = 3'd4;
      cmd_valid = (i == 1);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    issue(3'd4, 32'h0, 32'h0, 32'd46, 1);
    drain();

    // reset while in EXEC
    @(negedge clk);
    cmd_op = 3'd1; cmd_rs1 = 32'h1; cmd_rs2 = 32'h1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_payload", 64'(rsp_payload), 64'd0);
    chk("midrst_bb_in_a", bb_in_a, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(3'd4, 32'h0, 32'h0, 32'd0, 1);
    issue(3'd5, 32'h0, 32'h0, 32'd0, 1);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
